// File: rtl/sigmoid_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_pkg
// Shared definitions for the sigmoid PWL forward/backward units.
//   ONE_Q88      : 1.0 in Q8.8
//   DERIV_MAX    : largest value of y*(1-y) in Q.8 (0.25 -> 0x40)
//   q88_t        : signed Q8.8 sample
//   sig_sample_t : {y, g, tag} record as held in the activation buffer
// -----------------------------------------------------------------------------
package sigmoid_pkg;

    localparam logic [15:0] ONE_Q88   = 16'h0100;
    localparam logic [7:0]  DERIV_MAX = 8'h40;

    typedef logic signed [15:0] q88_t;

    typedef struct packed {
        q88_t       y;
        q88_t       g;
        logic [3:0] tag;
    } sig_sample_t;

endpackage

// File: rtl/sigmoid_pwl_backward_pipe_stage_ctl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctl
// Valid/ready control for one register slice of a stallable pipeline.
// The slice takes a new sample whenever it is empty or its current sample
// leaves downstream in the same cycle.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   up_valid   upstream offers a sample
//   up_ready   this slice can take a sample this cycle (combinational)
//   dn_ready   downstream can take this slice's sample
//   vld        slice holds a valid sample
//   load       data enable for this slice's data registers
// -----------------------------------------------------------------------------
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst,
    input  logic up_valid,
    output logic up_ready,
    input  logic dn_ready,
    output logic vld,
    output logic load
);

    // ~vld | (vld & dn_ready) reduces to ~vld | dn_ready
    assign up_ready = ~vld | dn_ready;
    assign load     = up_valid & up_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
        end else if (up_ready) begin
            vld <= up_valid;
        end
    end

endmodule

// File: rtl/sigmoid_pwl_backward.sv
// -----------------------------------------------------------------------------
// sigmoid_pwl_backward
// Backward pass of the sigmoid PWL unit: gx = g * y * (1 - y), with y taken
// from the forward pass and g the upstream gradient. Three-stage stallable
// valid/ready pipeline, one sample per clock.
//   S1: clamp y to [0, ONE], count clamp events, form 1 - y
//   S2: d = (y * (1 - y)) >> FRAC_W   (truncated, 0..0x40)
//   S3: gx = (g * d) >>> FRAC_W       (truncated or rounded half up)
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for y_in, g_in, tag_in
//   y_in                  forward output, nominal [0, ONE]
//   g_in                  upstream gradient, signed
//   tag_in                sideband, passed through unchanged
//   out_valid / out_ready output handshake for gx_out, tag_out
//   gx_out, tag_out       input gradient and its tag
//   clamp_cnt             accepted samples with y_in outside [0, ONE], saturating
//   busy                  any stage holds a valid sample
// Configuration:
//   SIGMOID_BWD_ROUND_EN  defined: S3 rounds half up; undefined: S3 truncates.
// -----------------------------------------------------------------------------
module sigmoid_pwl_backward
    import sigmoid_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] g_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] gx_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic [CNT_W-1:0]  clamp_cnt,
    output logic              busy
);

    localparam int P_W = DATA_W + FRAC_W + 1;

    localparam logic [FRAC_W:0] ONE_U =
        {1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [DATA_W-1:0] ONE_S =
        {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [P_W-1:0] HALF_LSB =
        {{(DATA_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic y_out_of_range(input logic signed [DATA_W-1:0] y);
        return y[DATA_W-1] | (y > ONE_S);
    endfunction

    function automatic logic [FRAC_W:0] clamp_y(input logic signed [DATA_W-1:0] y);
        if (y[DATA_W-1]) begin
            return '0;
        end else if (y > ONE_S) begin
            return ONE_U;
        end else begin
            return y[FRAC_W:0];
        end
    endfunction

    // y*(1-y) peaks at 0.25, so only the low FRAC_W bits of the shifted
    // product can ever be non-zero.
    function automatic logic [FRAC_W-1:0] deriv(input logic [FRAC_W:0] yc,
                                                input logic [FRAC_W:0] om);
        logic [2*FRAC_W+1:0] prod;
        prod = yc * om;
        return FRAC_W'(prod >> FRAC_W);
    endfunction

    // d <= 0.25 keeps |gx| <= |g|/4, so the low DATA_W bits never overflow.
    function automatic logic signed [DATA_W-1:0] grad_scale(
        input logic signed [DATA_W-1:0] g,
        input logic        [FRAC_W-1:0] d
    );
        logic signed [P_W-1:0] p;
        p = g * $signed({1'b0, d});
`ifdef SIGMOID_BWD_ROUND_EN
        p = p + HALF_LSB;
`endif
        return DATA_W'(p >>> FRAC_W);
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic rdy_p1, rdy_p2;
    logic ld_p0, ld_p1, ld_p2;

    logic        [FRAC_W:0]   yc_p0;
    logic        [FRAC_W:0]   om_p0;
    logic signed [DATA_W-1:0] g_p0;
    logic        [TAG_W-1:0]  tag_p0;

    logic        [FRAC_W-1:0] d_p1;
    logic signed [DATA_W-1:0] g_p1;
    logic        [TAG_W-1:0]  tag_p1;

    logic signed [DATA_W-1:0] gx_p2;
    logic        [TAG_W-1:0]  tag_p2;

    logic signed [DATA_W-1:0] y_s;
    logic        [FRAC_W:0]   yc_s;

    assign y_s  = $signed(y_in);
    assign yc_s = clamp_y(y_s);

    pipe_stage_ctl u_ctl_p0 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .dn_ready (rdy_p1),
        .vld      (vld_p0),
        .load     (ld_p0)
    );

    pipe_stage_ctl u_ctl_p1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (vld_p0),
        .up_ready (rdy_p1),
        .dn_ready (rdy_p2),
        .vld      (vld_p1),
        .load     (ld_p1)
    );

    pipe_stage_ctl u_ctl_p2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (vld_p1),
        .up_ready (rdy_p2),
        .dn_ready (out_ready),
        .vld      (vld_p2),
        .load     (ld_p2)
    );

    // ---- S1: clamp y, form 1 - y ----
    always_ff @(posedge clk) begin
        if (ld_p0) begin
            yc_p0  <= yc_s;
            om_p0  <= ONE_U - yc_s;
            g_p0   <= $signed(g_in);
            tag_p0 <= tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clamp_cnt <= '0;
        end else if (ld_p0 && y_out_of_range(y_s) && (clamp_cnt != '1)) begin
            clamp_cnt <= clamp_cnt + 1'b1;
        end
    end

    // ---- S2: derivative d = y*(1-y) ----
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            d_p1   <= deriv(yc_p0, om_p0);
            g_p1   <= g_p0;
            tag_p1 <= tag_p0;
        end
    end

    // ---- S3: gradient gx = g*d; output register, visible after reset ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gx_p2  <= '0;
            tag_p2 <= '0;
        end else if (ld_p2) begin
            gx_p2  <= grad_scale(g_p1, d_p1);
            tag_p2 <= tag_p1;
        end
    end

    assign out_valid = vld_p2;
    assign gx_out    = gx_p2;
    assign tag_out   = tag_p2;
    assign busy      = vld_p0 | vld_p1 | vld_p2;

endmodule
